pipe_ctrl_unit: RTL and testbench

//  Next-gen control for the 5-stage ARM-subset pipeline.

---
 rtl/pipe_ctrl_unit_pkg.sv | 85 ++++++++
 rtl/pipe_ctrl_unit_decoder.sv | 111 +++++++++++
 rtl/pipe_ctrl_unit.sv | 160 ++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared types, opcode patterns and helpers for the pipeline control unit.
package cpu_ctrl_pkg;

    localparam int CTRL_REG_W = 5;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'b000,
        ALU_ADD    = 3'b010,
        ALU_SUB    = 3'b011,
        ALU_AND    = 3'b100,
        ALU_OR     = 3'b101,
        ALU_XOR    = 3'b110
    } alu_op_t;

    typedef enum logic [1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_PC4 = 2'b10
    } mem_to_reg_t;

    // Immediate format selected in ID.
    typedef enum logic [1:0] {
        IMM_I  = 2'b00,
        IMM_D  = 2'b01,
        IMM_B  = 2'b10,
        IMM_CB = 2'b11
    } imm_sel_t;

    typedef struct packed {
        logic     reg2loc;
        logic     reg3loc;
        imm_sel_t imm_sel;
        logic     is_branch;
        logic     uncond_br;
        logic     br_taken;
    } ctrl_id_t;

    typedef struct packed {
        logic    alu_src;
        alu_op_t alu_op;
        logic    flag_set;
    } ctrl_ex_t;

    typedef struct packed {
        logic mem_write;
        logic read_en;
    } ctrl_mem_t;

    typedef struct packed {
        logic                  reg_write;
        mem_to_reg_t           mem_to_reg;
        logic [CTRL_REG_W-1:0] wb_rd;
    } ctrl_wb_t;

    // Opcode patterns on instr[31:21]; '?' bits are don't-care in casez.
    localparam logic [10:0] OP_ADDI = 11'b1001000100?;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_B    = 11'b000101?????;
    localparam logic [10:0] OP_BL   = 11'b100101?????;
    localparam logic [10:0] OP_BLT  = 11'b0101010????;
    localparam logic [10:0] OP_CBZ  = 11'b10110100???;
    localparam logic [10:0] OP_BR   = 11'b11010110000;

    // True when a load destination feeds a source actually read in ID.
    function automatic logic load_use_hit(
        input logic [CTRL_REG_W-1:0] ex_rd,
        input logic [CTRL_REG_W-1:0] rn,
        input logic [CTRL_REG_W-1:0] rm,
        input logic                  reads_rn,
        input logic                  reads_rm,
        input logic [CTRL_REG_W-1:0] zero_reg
    );
        logic hit;
        if (ex_rd == zero_reg) begin
            hit = 1'b0;
        end else begin
            hit = (reads_rn && (ex_rd == rn)) || (reads_rm && (ex_rd == rm));
        end
        return hit;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decoder.sv
// Pure combinational opcode decoder; every unlisted opcode yields an all-zero NOP.
module ctrl_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output ctrl_id_t    id_ctrl,
    output ctrl_ex_t    ex_ctrl,
    output ctrl_mem_t   mem_ctrl,
    output ctrl_wb_t    wb_ctrl,
    output logic        reads_rn,
    output logic        reads_rm,
    output logic        is_cbz,
    output logic        is_blt,
    output logic        illegal
);

    // Opcode to control-word table; defaults give the safe NOP.
    always_comb begin
        id_ctrl  = '0;
        ex_ctrl  = '0;
        mem_ctrl = '0;
        wb_ctrl  = '0;
        reads_rn = 1'b0;
        reads_rm = 1'b0;
        is_cbz   = 1'b0;
        is_blt   = 1'b0;
        illegal  = 1'b0;
        casez (opcode)
            OP_ADDI: begin
                id_ctrl.imm_sel   = IMM_I;
                ex_ctrl.alu_src   = 1'b1;
                ex_ctrl.alu_op    = ALU_ADD;
                wb_ctrl.reg_write = 1'b1;
                reads_rn          = 1'b1;
            end
            OP_ADDS: begin
                id_ctrl.reg2loc   = 1'b1;
                ex_ctrl.alu_op    = ALU_ADD;
                ex_ctrl.flag_set  = 1'b1;
                wb_ctrl.reg_write = 1'b1;
                reads_rn          = 1'b1;
                reads_rm          = 1'b1;
            end
            OP_SUBS: begin
                id_ctrl.reg2loc   = 1'b1;
                ex_ctrl.alu_op    = ALU_SUB;
                ex_ctrl.flag_set  = 1'b1;
                wb_ctrl.reg_write = 1'b1;
                reads_rn          = 1'b1;
                reads_rm          = 1'b1;
            end
            OP_LDUR: begin
                id_ctrl.imm_sel    = IMM_D;
                ex_ctrl.alu_src    = 1'b1;
                ex_ctrl.alu_op     = ALU_ADD;
                mem_ctrl.read_en   = 1'b1;
                wb_ctrl.reg_write  = 1'b1;
                wb_ctrl.mem_to_reg = MTR_MEM;
                reads_rn           = 1'b1;
            end
            OP_STUR: begin
                id_ctrl.imm_sel    = IMM_D;
                ex_ctrl.alu_src    = 1'b1;
                ex_ctrl.alu_op     = ALU_ADD;
                mem_ctrl.mem_write = 1'b1;
                reads_rn           = 1'b1;
                reads_rm           = 1'b1;
            end
            OP_B: begin
                id_ctrl.imm_sel   = IMM_B;
                id_ctrl.is_branch = 1'b1;
                id_ctrl.uncond_br = 1'b1;
                id_ctrl.br_taken  = 1'b1;
            end
            OP_BL: begin
                id_ctrl.reg3loc    = 1'b1;
                id_ctrl.imm_sel    = IMM_B;
                id_ctrl.is_branch  = 1'b1;
                id_ctrl.uncond_br  = 1'b1;
                id_ctrl.br_taken   = 1'b1;
                wb_ctrl.reg_write  = 1'b1;
                wb_ctrl.mem_to_reg = MTR_PC4;
            end
            OP_BLT: begin
                id_ctrl.imm_sel   = IMM_CB;
                id_ctrl.is_branch = 1'b1;
                is_blt            = 1'b1;
            end
            OP_CBZ: begin
                id_ctrl.imm_sel   = IMM_CB;
                id_ctrl.is_branch = 1'b1;
                ex_ctrl.alu_op    = ALU_PASS_B;
                reads_rm          = 1'b1;
                is_cbz            = 1'b1;
            end
            OP_BR: begin
                id_ctrl.is_branch = 1'b1;
                id_ctrl.uncond_br = 1'b1;
                id_ctrl.br_taken  = 1'b1;
                reads_rn          = 1'b1;
            end
            11'b00000000000: begin
                illegal = 1'b0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: decode, load-use hazard, branch resolution, NZVC flags and stage registers.
module pipe_ctrl_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int ZERO_REG   = 31,
    parameter int DELAY_SLOT = 1,
    parameter int LU_STALL   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      id_opcode,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm_rd,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_cbz_zero,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_c,
    output ctrl_id_t         id_ctrl,
    output ctrl_ex_t         ex_ctrl,
    output ctrl_mem_t        mem_ctrl,
    output ctrl_wb_t         wb_ctrl,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             illegal_op,
    output logic [3:0]       flags_q
);

    localparam logic [31:0] ZERO_REG_V = ZERO_REG;
    localparam logic [CTRL_REG_W-1:0] ZERO_ID = ZERO_REG_V[CTRL_REG_W-1:0];

    ctrl_id_t  dec_id_s;
    ctrl_ex_t  dec_ex_s;
    ctrl_mem_t dec_mem_s;
    ctrl_wb_t  dec_wb_s;
    logic      reads_rn_s;
    logic      reads_rm_s;
    logic      is_cbz_s;
    logic      is_blt_s;
    logic      illegal_s;
    logic      stall_s;
    logic [3:0] fwd_flags_s;
    ctrl_wb_t  id_wb_s;

    ctrl_ex_t  idex_ex_r;
    ctrl_mem_t idex_mem_r;
    ctrl_wb_t  idex_wb_r;
    ctrl_mem_t exmem_mem_r;
    ctrl_wb_t  exmem_wb_r;
    ctrl_wb_t  memwb_wb_r;
    logic [3:0] flags_r;

    ctrl_decoder u_dec (
        .opcode   (id_opcode),
        .id_ctrl  (dec_id_s),
        .ex_ctrl  (dec_ex_s),
        .mem_ctrl (dec_mem_s),
        .wb_ctrl  (dec_wb_s),
        .reads_rn (reads_rn_s),
        .reads_rm (reads_rm_s),
        .is_cbz   (is_cbz_s),
        .is_blt   (is_blt_s),
        .illegal  (illegal_s)
    );

    // Attach the destination id only to writers so NOPs stay all-zero.
    always_comb begin
        id_wb_s = dec_wb_s;
        if (dec_wb_s.reg_write) begin
            id_wb_s.wb_rd = id_rd;
        end else begin
            id_wb_s.wb_rd = '0;
        end
    end

    // Forward flags from an EX instruction that sets them; otherwise use the register.
    always_comb begin
        if (idex_ex_r.flag_set) begin
            fwd_flags_s = {alu_n, alu_z, alu_v, alu_c};
        end else begin
            fwd_flags_s = flags_r;
        end
    end

    // Load in EX whose destination is read by the ID instruction.
    always_comb begin
        if ((LU_STALL != 0) && idex_mem_r.read_en) begin
            stall_s = load_use_hit(idex_wb_r.wb_rd, id_rn, id_rm_rd,
                                   reads_rn_s, reads_rm_s, ZERO_ID);
        end else begin
            stall_s = 1'b0;
        end
    end

    // Resolve branch direction in ID; a stall suppresses any taken branch.
    always_comb begin
        id_ctrl = dec_id_s;
        if (stall_s) begin
            id_ctrl.br_taken = 1'b0;
        end else if (is_cbz_s) begin
            id_ctrl.br_taken = id_cbz_zero;
        end else if (is_blt_s) begin
            id_ctrl.br_taken = fwd_flags_s[3] ^ fwd_flags_s[1];
        end else begin
            id_ctrl.br_taken = dec_id_s.br_taken;
        end
    end

    // Flush IF/ID on a taken branch only when there is no delay slot.
    always_comb begin
        if (DELAY_SLOT == 0) begin
            ifid_flush = id_ctrl.br_taken & ~stall_s;
        end else begin
            ifid_flush = 1'b0;
        end
    end

    assign pc_hold    = stall_s;
    assign ifid_hold  = stall_s;
    assign illegal_op = illegal_s;
    assign ex_ctrl    = idex_ex_r;
    assign mem_ctrl   = exmem_mem_r;
    assign wb_ctrl    = memwb_wb_r;
    assign flags_q    = flags_r;

    // Stage registers and flag register; reset clears every in-flight control word.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_ex_r   <= '0;
            idex_mem_r  <= '0;
            idex_wb_r   <= '0;
            exmem_mem_r <= '0;
            exmem_wb_r  <= '0;
            memwb_wb_r  <= '0;
            flags_r     <= 4'b0000;
        end else begin
            if (stall_s) begin
                idex_ex_r  <= '0;
                idex_mem_r <= '0;
                idex_wb_r  <= '0;
            end else begin
                idex_ex_r  <= dec_ex_s;
                idex_mem_r <= dec_mem_s;
                idex_wb_r  <= id_wb_s;
            end
            exmem_mem_r <= idex_mem_r;
            exmem_wb_r  <= idex_wb_r;
            memwb_wb_r  <= exmem_wb_r;
            if (idex_ex_r.flag_set) begin
                flags_r <= {alu_n, alu_z, alu_v, alu_c};
            end else begin
                flags_r <= flags_r;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit; a second instance covers the no-delay-slot flush path.
module tb_pipe_ctrl_unit;
    import cpu_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [10:0] id_opcode;
    logic [4:0]  id_rn, id_rm_rd, id_rd;
    logic        id_cbz_zero, alu_n, alu_z, alu_v, alu_c;

    ctrl_id_t  id_ctrl, id_ctrl0;
    ctrl_ex_t  ex_ctrl, ex_ctrl0;
    ctrl_mem_t mem_ctrl, mem_ctrl0;
    ctrl_wb_t  wb_ctrl, wb_ctrl0;
    logic      pc_hold, ifid_hold, ifid_flush, illegal_op;
    logic      pc_hold0, ifid_hold0, ifid_flush0, illegal_op0;
    logic [3:0] flags_q, flags_q0;

    int checks = 0;
    int errors = 0;

    pipe_ctrl_unit #(.REG_W(5), .ZERO_REG(31), .DELAY_SLOT(1), .LU_STALL(1)) dut (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rn(id_rn),
        .id_rm_rd(id_rm_rd), .id_rd(id_rd), .id_cbz_zero(id_cbz_zero),
        .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
        .id_ctrl(id_ctrl), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .illegal_op(illegal_op), .flags_q(flags_q)
    );

    pipe_ctrl_unit #(.REG_W(5), .ZERO_REG(31), .DELAY_SLOT(0), .LU_STALL(1)) dut0 (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rn(id_rn),
        .id_rm_rd(id_rm_rd), .id_rd(id_rd), .id_cbz_zero(id_cbz_zero),
        .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
        .id_ctrl(id_ctrl0), .ex_ctrl(ex_ctrl0), .mem_ctrl(mem_ctrl0), .wb_ctrl(wb_ctrl0),
        .pc_hold(pc_hold0), .ifid_hold(ifid_hold0), .ifid_flush(ifid_flush0),
        .illegal_op(illegal_op0), .flags_q(flags_q0)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [10:0] op, input logic [4:0] rn,
                          input logic [4:0] rm, input logic [4:0] rd);
        id_opcode = op;
        id_rn     = rn;
        id_rm_rd  = rm;
        id_rd     = rd;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        id_cbz_zero = 1'b0;
        {alu_n, alu_z, alu_v, alu_c} = 4'b0000;
        set_id(11'h000, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_ex", 32'(ex_ctrl), 32'd0);
        chk("rst_mem", 32'(mem_ctrl), 32'd0);
        chk("rst_wb", 32'(wb_ctrl), 32'd0);
        chk("rst_flags", 32'(flags_q), 32'd0);
        chk("rst_hold", 32'({pc_hold, ifid_hold, ifid_flush0}), 32'd0);

        // ADDS through the pipe
        set_id(11'h558, 5'd2, 5'd3, 5'd4);
        chk("adds_illegal", 32'(illegal_op), 32'd0);
        chk("adds_reg2loc", 32'(id_ctrl.reg2loc), 32'd1);
        tick();
        set_id(11'h000, 5'd0, 5'd0, 5'd0);
        chk("adds_ex_op", 32'(ex_ctrl.alu_op), 32'd2);
        chk("adds_ex_fs", 32'(ex_ctrl.flag_set), 32'd1);
        chk("adds_ex_src", 32'(ex_ctrl.alu_src), 32'd0);
        tick();
        chk("adds_mem", 32'(mem_ctrl), 32'd0);
        tick();
        chk("adds_wb_we", 32'(wb_ctrl.reg_write), 32'd1);
        chk("adds_wb_rd", 32'(wb_ctrl.wb_rd), 32'd4);
        chk("adds_wb_mtr", 32'(wb_ctrl.mem_to_reg), 32'd0);

        // LDUR X1 then ADDS reading X1: one bubble
        set_id(11'h7C2, 5'd5, 5'd0, 5'd1);
        chk("ldur_nostall_first", 32'(pc_hold), 32'd0);
        tick();
        set_id(11'h558, 5'd1, 5'd6, 5'd7);
        chk("lu_pc_hold", 32'(pc_hold), 32'd1);
        chk("lu_ifid_hold", 32'(ifid_hold), 32'd1);
        tick();
        chk("lu_bubble_ex", 32'(ex_ctrl), 32'd0);
        chk("lu_mem_rd", 32'(mem_ctrl.read_en), 32'd1);
        chk("lu_released", 32'(pc_hold), 32'd0);
        tick();
        set_id(11'h000, 5'd0, 5'd0, 5'd0);
        chk("lu_adds_ex", 32'(ex_ctrl.flag_set), 32'd1);
        chk("lu_wb_mtr", 32'(wb_ctrl.mem_to_reg), 32'd1);
        chk("lu_wb_rd", 32'(wb_ctrl.wb_rd), 32'd1);

        // LDUR into X31 then reader of X31: no stall
        set_id(11'h7C2, 5'd5, 5'd0, 5'd31);
        tick();
        set_id(11'h558, 5'd31, 5'd31, 5'd8);
        chk("zr_nostall", 32'(pc_hold), 32'd0);
        tick();

        // LDUR X3 then BR X3: stall wins over branch
        set_id(11'h7C2, 5'd5, 5'd0, 5'd3);
        tick();
        set_id(11'h6B0, 5'd3, 5'd0, 5'd0);
        chk("br_stall", 32'(pc_hold), 32'd1);
        chk("br_stall_taken", 32'(id_ctrl.br_taken), 32'd0);
        chk("br_stall_flush", 32'(ifid_flush0), 32'd0);
        tick();
        chk("br_after_taken", 32'(id_ctrl.br_taken), 32'd1);
        chk("br_after_flush", 32'(ifid_flush0), 32'd1);
        set_id(11'h000, 5'd0, 5'd0, 5'd0);
        tick();

        // SUBS N=1,V=0 in EX while BLT in ID
        set_id(11'h758, 5'd1, 5'd2, 5'd3);
        tick();
        {alu_n, alu_z, alu_v, alu_c} = 4'b1000;
        set_id(11'h2A5, 5'd0, 5'd0, 5'd0);
        chk("blt_taken_fwd", 32'(id_ctrl.br_taken), 32'd1);
        chk("blt_flush_ds0", 32'(ifid_flush0), 32'd1);
        chk("blt_flush_ds1", 32'(ifid_flush), 32'd0);
        tick();
        {alu_n, alu_z, alu_v, alu_c} = 4'b0000;
        #1;
        chk("blt_flags_q", 32'(flags_q), 32'b1000);
        chk("blt_taken_reg", 32'(id_ctrl.br_taken), 32'd1);

        // ADDS with N=V=1 in EX: BLT not taken
        set_id(11'h558, 5'd1, 5'd2, 5'd3);
        tick();
        {alu_n, alu_z, alu_v, alu_c} = 4'b1010;
        set_id(11'h2A0, 5'd0, 5'd0, 5'd0);
        chk("blt_not_taken", 32'(id_ctrl.br_taken), 32'd0);
        tick();
        {alu_n, alu_z, alu_v, alu_c} = 4'b0000;
        #1;
        chk("flags_nv", 32'(flags_q), 32'b1010);

        // B: flush only without delay slot
        set_id(11'h0A3, 5'd0, 5'd0, 5'd0);
        chk("b_taken", 32'(id_ctrl.br_taken), 32'd1);
        chk("b_flush_ds0", 32'(ifid_flush0), 32'd1);
        chk("b_flush_ds1", 32'(ifid_flush), 32'd0);
        tick();
        set_id(11'h000, 5'd0, 5'd0, 5'd0);
        chk("b_flush_clear", 32'(ifid_flush0), 32'd0);

        // CBZ follows the forwarded zero test
        id_cbz_zero = 1'b1;
        set_id(11'h5A4, 5'd0, 5'd9, 5'd0);
        chk("cbz_taken", 32'(id_ctrl.br_taken), 32'd1);
        id_cbz_zero = 1'b0;
        #1;
        chk("cbz_not_taken", 32'(id_ctrl.br_taken), 32'd0);

        // Illegal and zero opcodes
        set_id(11'h7FF, 5'd1, 5'd2, 5'd3);
        chk("ill_flag", 32'(illegal_op), 32'd1);
        chk("ill_id", 32'(id_ctrl), 32'd0);
        tick();
        chk("ill_ex", 32'(ex_ctrl), 32'd0);
        set_id(11'h000, 5'd1, 5'd2, 5'd3);
        chk("nop_legal", 32'(illegal_op), 32'd0);
        tick();
        tick();
        chk("ill_wb", 32'(wb_ctrl), 32'd0);

        // Reset with STUR in MEM discards it
        set_id(11'h7C0, 5'd4, 5'd5, 5'd0);
        tick();
        set_id(11'h000, 5'd0, 5'd0, 5'd0);
        tick();
        chk("stur_mem_wr", 32'(mem_ctrl.mem_write), 32'd1);
        reset = 1'b1;
        tick();
        chk("rst_mid_mem", 32'(mem_ctrl), 32'd0);
        chk("rst_mid_flags", 32'(flags_q), 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_mid_wb", 32'(wb_ctrl), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
